// File: rtl/sfifo_mon.sv
// sfifo_mon: parametrised synchronous FIFO with first-word-fall-through read, occupancy and error monitoring.
// Latency: written data reaches o_rd_data one cycle after acceptance into an empty FIFO; status outputs are combinational from state.
// Backpressure: a write while full or a read while empty is dropped and reported by a one-cycle pulse plus a sticky flag.
//
// Ports:
//   i_clk, i_reset        clock; synchronous active-high reset (dominates flush and stat-clear)
//   i_flush               synchronous discard of all contents; stats untouched
//   i_wr_en, i_wr_data    write request and data; o_full reports no space
//   i_rd, o_rd_data       pop request and head entry; o_empty reports no data
//   o_count               occupancy 0..DEPTH; o_almost_full / o_almost_empty compare it to the thresholds
//   o_overflow/underflow  one-cycle pulse for a write/read rejected the previous cycle
//   o_ovf/udf_sticky      latched error flags; i_clr_stat clears them and o_peak
//   o_peak                highest occupancy seen since reset or stat-clear (lags o_count by one cycle)
module sfifo_mon #(
  parameter int DW       = 8,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_full,
  input  logic          i_rd,
  output logic [DW-1:0] o_rd_data,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_almost_full,
  output logic          o_almost_empty,
  output logic          o_overflow,
  output logic          o_underflow,
  output logic          o_ovf_sticky,
  output logic          o_udf_sticky,
  input  logic          i_clr_stat,
  output logic [AW:0]   o_peak
);

  localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_overflow;
  logic          r_underflow;
  logic          r_ovf_sticky;
  logic          r_udf_sticky;
  logic [AW:0]   r_peak;

  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_ovf_evt;
  logic          w_udf_evt;

  // Extra wrap bit on each pointer distinguishes full from empty when the low bits match.
  assign w_empty = (r_rd_ptr == r_wr_ptr);
  assign w_full  = (r_rd_ptr[AW] != r_wr_ptr[AW]) && (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]);
  assign w_count = r_wr_ptr - r_rd_ptr;

  // Full/empty are judged on current state only, so a same-cycle pop never makes room for a push
  // and a same-cycle push never feeds a pop.
  assign w_wr_acc  = i_wr_en & ~w_full  & ~i_flush & ~i_reset;
  assign w_rd_acc  = i_rd    & ~w_empty & ~i_flush & ~i_reset;
  assign w_ovf_evt = i_wr_en &  w_full  & ~i_flush;
  assign w_udf_evt = i_rd    &  w_empty & ~i_flush;

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_udf_sticky <= 1'b0;
      r_peak       <= '0;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ONE;
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ONE;
      end

      r_overflow  <= w_ovf_evt;
      r_underflow <= w_udf_evt;

      // A new error coinciding with a stat-clear keeps the flag set.
      if (w_ovf_evt)       r_ovf_sticky <= 1'b1;
      else if (i_clr_stat) r_ovf_sticky <= 1'b0;

      if (w_udf_evt)       r_udf_sticky <= 1'b1;
      else if (i_clr_stat) r_udf_sticky <= 1'b0;

      // Watermark samples the registered occupancy, so it trails o_count by one cycle.
      if (i_clr_stat)          r_peak <= '0;
      else if (w_count > r_peak) r_peak <= w_count;
    end
  end

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_count        = w_count;
  assign o_rd_data      = r_mem[r_rd_ptr[AW-1:0]];
  assign o_almost_full  = (w_count >= AF_L);
  assign o_almost_empty = (w_count <= AE_L);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;
  assign o_ovf_sticky   = r_ovf_sticky;
  assign o_udf_sticky   = r_udf_sticky;
  assign o_peak         = r_peak;

endmodule

// File: tb/tb_sfifo_mon.sv
// tb_sfifo_mon: directed bench for sfifo_mon at DW=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
// Latency: inputs are set after a rising edge, outputs are sampled 1 time unit after the next edge.
// Backpressure: rejected writes/reads are exercised and their pulses and sticky flags are checked.
module tb_sfifo_mon;

  logic       i_clk;
  logic       i_reset;
  logic       i_flush;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       o_full;
  logic       i_rd;
  logic [7:0] o_rd_data;
  logic       o_empty;
  logic [3:0] o_count;
  logic       o_almost_full;
  logic       o_almost_empty;
  logic       o_overflow;
  logic       o_underflow;
  logic       o_ovf_sticky;
  logic       o_udf_sticky;
  logic       i_clr_stat;
  logic [3:0] o_peak;

  int n_checks = 0;
  int n_fail   = 0;

  sfifo_mon #(.DW(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_flush        (i_flush),
    .i_wr_en        (i_wr_en),
    .i_wr_data      (i_wr_data),
    .o_full         (o_full),
    .i_rd           (i_rd),
    .o_rd_data      (o_rd_data),
    .o_empty        (o_empty),
    .o_count        (o_count),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow),
    .o_ovf_sticky   (o_ovf_sticky),
    .o_udf_sticky   (o_udf_sticky),
    .i_clr_stat     (i_clr_stat),
    .o_peak         (o_peak)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic idle();
    i_reset = 1'b0; i_flush = 1'b0; i_wr_en = 1'b0; i_rd = 1'b0; i_clr_stat = 1'b0; i_wr_data = 8'h00;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    i_reset = 1'b1;
    tick(); tick();
    idle();
    n_checks++; if (o_empty !== 1'b1)        begin n_fail++; $display("FAIL rst_empty got %b exp 1", o_empty); end
    n_checks++; if (o_full !== 1'b0)         begin n_fail++; $display("FAIL rst_full got %b exp 0", o_full); end
    n_checks++; if (o_count !== 4'd0)        begin n_fail++; $display("FAIL rst_count got %0d exp 0", o_count); end
    n_checks++; if (o_almost_full !== 1'b0)  begin n_fail++; $display("FAIL rst_af got %b exp 0", o_almost_full); end
    n_checks++; if (o_almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_ae got %b exp 1", o_almost_empty); end
    n_checks++; if ({o_overflow, o_underflow, o_ovf_sticky, o_udf_sticky} !== 4'b0000)
      begin n_fail++; $display("FAIL rst_err got %b exp 0000", {o_overflow, o_underflow, o_ovf_sticky, o_udf_sticky}); end
    n_checks++; if (o_peak !== 4'd0)         begin n_fail++; $display("FAIL rst_peak got %0d exp 0", o_peak); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      i_wr_en = 1'b1; i_wr_data = 8'(8'h10 + i);
      tick();
      n_checks++; if (o_count !== 4'(i + 1))         begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, o_count, i + 1); end
      n_checks++; if (o_almost_empty !== (i + 1 <= 1)) begin n_fail++; $display("FAIL fill_ae[%0d] got %b exp %b", i, o_almost_empty, (i + 1 <= 1)); end
      n_checks++; if (o_almost_full !== (i + 1 >= 6))  begin n_fail++; $display("FAIL fill_af[%0d] got %b exp %b", i, o_almost_full, (i + 1 >= 6)); end
      n_checks++; if (o_full !== (i + 1 == 8))         begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, o_full, (i + 1 == 8)); end
    end
    idle();
    n_checks++; if (o_peak !== 4'd7) begin n_fail++; $display("FAIL fill_peak_lag got %0d exp 7", o_peak); end
    tick();
    n_checks++; if (o_peak !== 4'd8)       begin n_fail++; $display("FAIL fill_peak got %0d exp 8", o_peak); end
    n_checks++; if (o_rd_data !== 8'h10)   begin n_fail++; $display("FAIL fill_head got %h exp 10", o_rd_data); end
  endtask

  task automatic test_full_rw();
    i_wr_en = 1'b1; i_wr_data = 8'hAA; i_rd = 1'b1;
    tick();
    idle();
    n_checks++; if (o_count !== 4'd7)     begin n_fail++; $display("FAIL frw_count got %0d exp 7", o_count); end
    n_checks++; if (o_overflow !== 1'b1)  begin n_fail++; $display("FAIL frw_ovf got %b exp 1", o_overflow); end
    n_checks++; if (o_ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL frw_ovf_sticky got %b exp 1", o_ovf_sticky); end
    tick();
    n_checks++; if (o_overflow !== 1'b0)  begin n_fail++; $display("FAIL frw_ovf_pulse_end got %b exp 0", o_overflow); end
    n_checks++; if (o_ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL frw_ovf_hold got %b exp 1", o_ovf_sticky); end
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (o_rd_data !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL frw_data[%0d] got %h exp %h", i, o_rd_data, 8'(8'h11 + i)); end
      i_rd = 1'b1;
      tick();
    end
    idle();
    n_checks++; if (o_empty !== 1'b1)      begin n_fail++; $display("FAIL frw_drained got %b exp 1", o_empty); end
    n_checks++; if (o_udf_sticky !== 1'b0) begin n_fail++; $display("FAIL frw_udf_sticky got %b exp 0", o_udf_sticky); end
  endtask

  task automatic test_empty_rw();
    i_rd = 1'b1; i_wr_en = 1'b1; i_wr_data = 8'h55;
    tick();
    idle();
    n_checks++; if (o_underflow !== 1'b1)  begin n_fail++; $display("FAIL erw_udf got %b exp 1", o_underflow); end
    n_checks++; if (o_udf_sticky !== 1'b1) begin n_fail++; $display("FAIL erw_udf_sticky got %b exp 1", o_udf_sticky); end
    n_checks++; if (o_count !== 4'd1)      begin n_fail++; $display("FAIL erw_count got %0d exp 1", o_count); end
    n_checks++; if (o_rd_data !== 8'h55)   begin n_fail++; $display("FAIL erw_data got %h exp 55", o_rd_data); end
    i_rd = 1'b1;
    tick();
    idle();
    n_checks++; if (o_underflow !== 1'b0)  begin n_fail++; $display("FAIL erw_udf_pulse_end got %b exp 0", o_underflow); end
    n_checks++; if (o_empty !== 1'b1)      begin n_fail++; $display("FAIL erw_empty got %b exp 1", o_empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    for (int i = 0; i < 4; i++) begin
      i_wr_en = 1'b1; i_wr_data = 8'(8'hF0 + i); q.push_back(8'(8'hF0 + i));
      tick();
    end
    idle();
    for (int c = 0; c < 20; c++) begin
      n_checks++; if (o_rd_data !== q[0]) begin n_fail++; $display("FAIL wrap_data[%0d] got %h exp %h", c, o_rd_data, q[0]); end
      i_wr_en = 1'b1; i_rd = 1'b1; i_wr_data = 8'(c);
      tick();
      void'(q.pop_front());
      q.push_back(8'(c));
      n_checks++; if (o_count !== 4'd4) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d exp 4", c, o_count); end
    end
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      i_rd = 1'b1;
      tick();
    end
    idle();
    // Stat-clear coinciding with an underflow: underflow sticky survives, overflow sticky and peak clear.
    i_clr_stat = 1'b1; i_rd = 1'b1;
    tick();
    idle();
    n_checks++; if (o_udf_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_udf_setwins got %b exp 1", o_udf_sticky); end
    n_checks++; if (o_ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b exp 0", o_ovf_sticky); end
    n_checks++; if (o_peak !== 4'd0)       begin n_fail++; $display("FAIL clr_peak got %0d exp 0", o_peak); end
    for (int i = 0; i < 5; i++) begin
      i_wr_en = 1'b1; i_wr_data = 8'(8'hA0 + i);
      tick();
    end
    idle();
    i_flush = 1'b1; i_wr_en = 1'b1; i_wr_data = 8'hBB;
    tick();
    idle();
    n_checks++; if (o_count !== 4'd0)      begin n_fail++; $display("FAIL flush_count got %0d exp 0", o_count); end
    n_checks++; if (o_empty !== 1'b1)      begin n_fail++; $display("FAIL flush_empty got %b exp 1", o_empty); end
    n_checks++; if (o_overflow !== 1'b0)   begin n_fail++; $display("FAIL flush_ovf got %b exp 0", o_overflow); end
    n_checks++; if (o_peak !== 4'd5)       begin n_fail++; $display("FAIL flush_peak got %0d exp 5", o_peak); end
    n_checks++; if (o_udf_sticky !== 1'b1) begin n_fail++; $display("FAIL flush_udf_sticky got %b exp 1", o_udf_sticky); end
    n_checks++; if (o_ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL flush_ovf_sticky got %b exp 0", o_ovf_sticky); end
    tick();
    n_checks++; if (o_peak !== 4'd5)       begin n_fail++; $display("FAIL flush_peak_hold got %0d exp 5", o_peak); end
  endtask

  task automatic test_clr_stat();
    for (int i = 0; i < 8; i++) begin
      i_wr_en = 1'b1; i_wr_data = 8'(8'h30 + i);
      tick();
    end
    idle();
    i_wr_en = 1'b1; i_wr_data = 8'hCC; i_clr_stat = 1'b1;
    tick();
    idle();
    n_checks++; if (o_overflow !== 1'b1)   begin n_fail++; $display("FAIL clrovf_pulse got %b exp 1", o_overflow); end
    n_checks++; if (o_ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL clrovf_setwins got %b exp 1", o_ovf_sticky); end
    n_checks++; if (o_udf_sticky !== 1'b0) begin n_fail++; $display("FAIL clrovf_udf got %b exp 0", o_udf_sticky); end
    n_checks++; if (o_peak !== 4'd0)       begin n_fail++; $display("FAIL clrovf_peak got %0d exp 0", o_peak); end
    i_clr_stat = 1'b1;
    tick();
    idle();
    n_checks++; if (o_ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_alone_ovf got %b exp 0", o_ovf_sticky); end
    n_checks++; if (o_overflow !== 1'b0)   begin n_fail++; $display("FAIL clr_alone_pulse got %b exp 0", o_overflow); end
    tick();
    n_checks++; if (o_peak !== 4'd8)       begin n_fail++; $display("FAIL clr_peak_regrow got %0d exp 8", o_peak); end
  endtask

  task automatic test_reset_midstream();
    // Full FIFO with a rejected write and a pop pending while reset is asserted.
    i_reset = 1'b1; i_wr_en = 1'b1; i_rd = 1'b1; i_wr_data = 8'hDD;
    tick();
    idle();
    n_checks++; if (o_empty !== 1'b1)        begin n_fail++; $display("FAIL mrst_empty got %b exp 1", o_empty); end
    n_checks++; if (o_full !== 1'b0)         begin n_fail++; $display("FAIL mrst_full got %b exp 0", o_full); end
    n_checks++; if (o_count !== 4'd0)        begin n_fail++; $display("FAIL mrst_count got %0d exp 0", o_count); end
    n_checks++; if (o_almost_full !== 1'b0)  begin n_fail++; $display("FAIL mrst_af got %b exp 0", o_almost_full); end
    n_checks++; if (o_almost_empty !== 1'b1) begin n_fail++; $display("FAIL mrst_ae got %b exp 1", o_almost_empty); end
    n_checks++; if ({o_overflow, o_underflow, o_ovf_sticky, o_udf_sticky} !== 4'b0000)
      begin n_fail++; $display("FAIL mrst_err got %b exp 0000", {o_overflow, o_underflow, o_ovf_sticky, o_udf_sticky}); end
    n_checks++; if (o_peak !== 4'd0)         begin n_fail++; $display("FAIL mrst_peak got %0d exp 0", o_peak); end
    tick();
    n_checks++; if (o_count !== 4'd0)        begin n_fail++; $display("FAIL mrst_after_count got %0d exp 0", o_count); end
    n_checks++; if (o_peak !== 4'd0)         begin n_fail++; $display("FAIL mrst_after_peak got %0d exp 0", o_peak); end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_flush();
    test_clr_stat();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
